// File: rtl/std_lane_pkg.sv
`default_nettype none
// ============================================================================
// Module   : std_lane_pkg
// Brief    : Shared types and helpers for the std lane aggregator
// Revision : 1.0
// ============================================================================
package std_lane_pkg;

    typedef enum logic [1:0] {
        STD_MOD     = 2'b00,
        STD_SOD     = 2'b01,
        STD_EOD     = 2'b10,
        STD_SOD_EOD = 2'b11
    } std_cntl_t;

    typedef enum logic {
        AGG_IDLE   = 1'b0,
        AGG_LOCKED = 1'b1
    } agg_state_t;

    function automatic logic is_sod(input logic [1:0] cntl);
        return (cntl == STD_SOD) || (cntl == STD_SOD_EOD);
    endfunction

    function automatic logic is_eod(input logic [1:0] cntl);
        return (cntl == STD_EOD) || (cntl == STD_SOD_EOD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/std_lane_fifo.sv
`default_nettype none
// ============================================================================
// Module   : std_lane_fifo
// Brief    : Per-lane skid FIFO with registered occupancy count
// Revision : 1.0
// ============================================================================
module std_lane_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_push;
    logic             w_pop;

    // A full FIFO refuses the push even if a pop happens in the same cycle.
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_full  = (count_q == C_DEPTH);
    assign o_empty = (count_q == '0);
    assign o_head  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            mem_d[wr_ptr_q] = i_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire

// File: rtl/std_lane_aggregator.sv
`default_nettype none
// ============================================================================
// Module   : std_lane_aggregator
// Brief    : Merges NUM_LANES std lane streams onto one upstream stack bus
//            with packet-locked round-robin arbitration and lane id tagging
// Revision : 1.0
// ============================================================================
module std_lane_aggregator
    import std_lane_pkg::*;
#(
    parameter int NUM_LANES  = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int LANE_ID_W  = $clog2(NUM_LANES)
) (
    input  logic                        clk,
    input  logic                        reset_poweron,
    input  logic [NUM_LANES-1:0]        lane_valid,
    input  logic [NUM_LANES*2-1:0]      lane_cntl,
    input  logic [NUM_LANES*DATA_W-1:0] lane_data,
    output logic [NUM_LANES-1:0]        lane_ready,
    output logic                        up_valid,
    output logic [1:0]                  up_cntl,
    output logic [LANE_ID_W-1:0]        up_lane_id,
    output logic [DATA_W-1:0]           up_data,
    input  logic                        up_ready,
    output logic [NUM_LANES-1:0]        lane_err,
    output logic                        busy
);

    localparam int ENTRY_W = DATA_W + 2;

    logic [NUM_LANES-1:0] w_full;
    logic [NUM_LANES-1:0] w_empty;
    logic [NUM_LANES-1:0] w_pop;
    logic [ENTRY_W-1:0]   w_head [NUM_LANES];

    agg_state_t           state_q, state_d;
    logic [LANE_ID_W-1:0] grant_q, grant_d;
    logic [LANE_ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [NUM_LANES-1:0] err_q, err_d;
    logic                 first_q, first_d;

    logic                 w_arb_found;
    logic [LANE_ID_W-1:0] w_arb_lane;
    logic [1:0]           w_arb_cntl;
    logic [1:0]           w_grant_cntl;

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            std_lane_fifo #(
                .WIDTH (ENTRY_W),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rst     (reset_poweron),
                .i_push  (lane_valid[i]),
                .i_data  ({lane_cntl[2*i +: 2], lane_data[DATA_W*i +: DATA_W]}),
                .i_pop   (w_pop[i]),
                .o_head  (w_head[i]),
                .o_full  (w_full[i]),
                .o_empty (w_empty[i])
            );
        end
    endgenerate

    assign lane_ready = ~w_full;
    assign lane_err   = err_q;
    assign busy       = (~&w_empty) | (state_q == AGG_LOCKED);

    // First non-empty lane searching upward from the lane after rr_ptr.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_lane  = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            int idx;
            idx = (int'(rr_ptr_q) + 1 + k) % NUM_LANES;
            if (!w_arb_found && !w_empty[idx]) begin
                w_arb_found = 1'b1;
                w_arb_lane  = LANE_ID_W'(idx);
            end
        end
    end

    assign w_arb_cntl   = w_head[w_arb_lane][ENTRY_W-1 -: 2];
    assign w_grant_cntl = w_head[grant_q][ENTRY_W-1 -: 2];

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        err_d      = err_q;
        first_d    = first_q;
        w_pop      = '0;
        up_valid   = 1'b0;
        up_cntl    = '0;
        up_lane_id = '0;
        up_data    = '0;
        case (state_q)
            AGG_IDLE: begin
                if (w_arb_found) begin
                    rr_ptr_d = w_arb_lane;
                    if (is_sod(w_arb_cntl)) begin
                        grant_d = w_arb_lane;
                        first_d = 1'b1;
                        state_d = AGG_LOCKED;
                    end else begin
                        // Orphan mid/end beat with no open packet: drop it.
                        w_pop[w_arb_lane] = 1'b1;
                        err_d[w_arb_lane] = 1'b1;
                    end
                end
            end
            AGG_LOCKED: begin
                if (!w_empty[grant_q]) begin
                    up_valid   = 1'b1;
                    up_cntl    = w_grant_cntl;
                    up_lane_id = grant_q;
                    up_data    = w_head[grant_q][DATA_W-1:0];
                    if (up_ready) begin
                        w_pop[grant_q] = 1'b1;
                        first_d        = 1'b0;
                        if (!first_q && is_sod(w_grant_cntl)) begin
                            err_d[grant_q] = 1'b1;
                        end
                        if (is_eod(w_grant_cntl)) begin
                            state_d = AGG_IDLE;
                        end
                    end
                end
            end
            default: state_d = AGG_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            state_q  <= AGG_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= LANE_ID_W'(NUM_LANES - 1);
            err_q    <= '0;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
            first_q  <= first_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_std_lane_aggregator.sv
`default_nettype none
// ============================================================================
// Module   : tb_std_lane_aggregator
// Brief    : Directed self-checking bench for std_lane_aggregator
// Revision : 1.0
// ============================================================================
module tb_std_lane_aggregator;

    localparam int NUM_LANES = 32;
    localparam int DATA_W    = 32;
    localparam int LANE_ID_W = 5;

    localparam logic [1:0] C_MOD = 2'b00;
    localparam logic [1:0] C_SOD = 2'b01;
    localparam logic [1:0] C_EOD = 2'b10;
    localparam logic [1:0] C_SE  = 2'b11;

    logic                        clk = 1'b0;
    logic                        reset_poweron = 1'b1;
    logic [NUM_LANES-1:0]        lane_valid = '0;
    logic [NUM_LANES*2-1:0]      lane_cntl = '0;
    logic [NUM_LANES*DATA_W-1:0] lane_data = '0;
    logic [NUM_LANES-1:0]        lane_ready;
    logic                        up_valid;
    logic [1:0]                  up_cntl;
    logic [LANE_ID_W-1:0]        up_lane_id;
    logic [DATA_W-1:0]           up_data;
    logic                        up_ready = 1'b1;
    logic [NUM_LANES-1:0]        lane_err;
    logic                        busy;

    int n_assert = 0;
    int n_fail   = 0;

    std_lane_aggregator #(
        .NUM_LANES  (NUM_LANES),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset_poweron (reset_poweron),
        .lane_valid    (lane_valid),
        .lane_cntl     (lane_cntl),
        .lane_data     (lane_data),
        .lane_ready    (lane_ready),
        .up_valid      (up_valid),
        .up_cntl       (up_cntl),
        .up_lane_id    (up_lane_id),
        .up_data       (up_data),
        .up_ready      (up_ready),
        .lane_err      (lane_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int lane, input logic [1:0] c, input logic [31:0] d);
        lane_valid[lane]            = 1'b1;
        lane_cntl[2*lane +: 2]      = c;
        lane_data[DATA_W*lane +: DATA_W] = d;
    endtask

    task automatic send(input int lane, input logic [1:0] c, input logic [31:0] d);
        drive(lane, c, d);
        tick();
        lane_valid = '0;
    endtask

    // Waits (bounded) for a valid beat, checks it, then lets it be consumed.
    task automatic expect_beat(input string tag, input int id, input logic [1:0] c, input logic [31:0] d);
        int k;
        k = 0;
        while (!up_valid && k < 20) begin
            tick();
            k++;
        end
        check({tag, "_valid"}, 64'(up_valid), 64'd1);
        check({tag, "_id"},    64'(up_lane_id), 64'(id));
        check({tag, "_cntl"},  64'(up_cntl), 64'(c));
        check({tag, "_data"},  64'(up_data), 64'(d));
        tick();
    endtask

    logic [1:0]  b_cntl [5];
    logic [31:0] rec_data [8];
    logic [1:0]  rec_cntl [8];
    logic [4:0]  rec_id   [8];

    initial begin
        int idx;
        int nrec;
        logic acc;

        // ---------------- reset ----------------
        tick();
        tick();
        reset_poweron = 1'b0;
        check("rst_up_valid",   64'(up_valid), 64'd0);
        check("rst_up_data",    64'(up_data), 64'd0);
        check("rst_up_cntl",    64'(up_cntl), 64'd0);
        check("rst_up_lane_id", 64'(up_lane_id), 64'd0);
        check("rst_lane_ready", 64'(lane_ready), 64'hFFFF_FFFF);
        check("rst_lane_err",   64'(lane_err), 64'd0);
        check("rst_busy",       64'(busy), 64'd0);

        // ---------------- lane 3 three-beat packet ----------------
        drive(3, C_SOD, 32'hA);
        tick();
        check("l3_idle_no_beat", 64'(up_valid), 64'd0);
        check("l3_busy",         64'(busy), 64'd1);
        drive(3, C_MOD, 32'hB);
        tick();
        check("l3_b0_valid", 64'(up_valid), 64'd1);
        check("l3_b0_id",    64'(up_lane_id), 64'd3);
        check("l3_b0_cntl",  64'(up_cntl), 64'(C_SOD));
        check("l3_b0_data",  64'(up_data), 64'hA);
        drive(3, C_EOD, 32'hC);
        tick();
        lane_valid = '0;
        check("l3_b1_data", 64'(up_data), 64'hB);
        check("l3_b1_cntl", 64'(up_cntl), 64'(C_MOD));
        tick();
        check("l3_b2_data", 64'(up_data), 64'hC);
        check("l3_b2_cntl", 64'(up_cntl), 64'(C_EOD));
        tick();
        check("l3_end_valid", 64'(up_valid), 64'd0);
        check("l3_end_busy",  64'(busy), 64'd0);

        // ---------------- round robin over lanes 0,1,2 then 31 before 0 ----------------
        drive(0, C_SE, 32'h10);
        drive(1, C_SE, 32'h11);
        drive(2, C_SE, 32'h12);
        tick();
        lane_valid = '0;
        expect_beat("rr0", 0, C_SE, 32'h10);
        expect_beat("rr1", 1, C_SE, 32'h11);
        expect_beat("rr2", 2, C_SE, 32'h12);
        drive(0, C_SE, 32'h20);
        drive(31, C_SE, 32'h31);
        tick();
        lane_valid = '0;
        expect_beat("rr31", 31, C_SE, 32'h31);
        expect_beat("rr0b", 0, C_SE, 32'h20);

        // ---------------- backpressure on lane 5 ----------------
        b_cntl[0] = C_SOD;
        b_cntl[1] = C_MOD;
        b_cntl[2] = C_MOD;
        b_cntl[3] = C_EOD;
        b_cntl[4] = C_SE;
        idx  = 0;
        nrec = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            up_ready = (cyc >= 10);
            if (cyc == 3) begin
                check("bp_early_valid", 64'(up_valid), 64'd1);
                check("bp_early_data",  64'(up_data), 64'h50);
            end
            if (cyc == 9) begin
                check("bp_lane_ready5", 64'(lane_ready[5]), 64'd0);
                check("bp_accepted",    64'(idx), 64'd4);
                check("bp_hold_valid",  64'(up_valid), 64'd1);
                check("bp_hold_data",   64'(up_data), 64'h50);
                check("bp_hold_cntl",   64'(up_cntl), 64'(C_SOD));
            end
            if (idx < 5) begin
                drive(5, b_cntl[idx], 32'h50 + 32'(idx));
            end else begin
                lane_valid = '0;
            end
            acc = lane_ready[5] && (idx < 5);
            if (up_valid && up_ready && nrec < 8) begin
                rec_data[nrec] = up_data;
                rec_cntl[nrec] = up_cntl;
                rec_id[nrec]   = up_lane_id;
                nrec++;
            end
            tick();
            if (acc) idx++;
        end
        lane_valid = '0;
        up_ready   = 1'b1;
        check("bp_count", 64'(nrec), 64'd5);
        for (int j = 0; j < 5; j++) begin
            check($sformatf("bp_data%0d", j), 64'(rec_data[j]), 64'(32'h50 + 32'(j)));
            check($sformatf("bp_cntl%0d", j), 64'(rec_cntl[j]), 64'(b_cntl[j]));
            check($sformatf("bp_id%0d", j),   64'(rec_id[j]), 64'd5);
        end

        // ---------------- orphan MOD on lane 7 ----------------
        send(7, C_MOD, 32'h70);
        check("orph_no_valid", 64'(up_valid), 64'd0);
        tick();
        check("orph_err",      64'(lane_err), 64'h80);
        check("orph_no_valid2", 64'(up_valid), 64'd0);
        check("orph_busy",     64'(busy), 64'd0);
        send(7, C_SE, 32'h71);
        expect_beat("orph_next", 7, C_SE, 32'h71);

        // ---------------- lane 2 stalls mid-packet, lane 4 waits ----------------
        drive(2, C_SOD, 32'h20);
        drive(4, C_SE, 32'h40);
        tick();
        lane_valid = '0;
        expect_beat("stall_l2_sod", 2, C_SOD, 32'h20);
        check("stall_gap_valid", 64'(up_valid), 64'd0);
        check("stall_gap_busy",  64'(busy), 64'd1);
        tick();
        tick();
        tick();
        check("stall_still_gap", 64'(up_valid), 64'd0);
        send(2, C_EOD, 32'h21);
        expect_beat("stall_l2_eod", 2, C_EOD, 32'h21);
        expect_beat("stall_l4", 4, C_SE, 32'h40);

        // ---------------- SOD inside an open packet ----------------
        up_ready = 1'b0;
        send(6, C_SOD, 32'h60);
        send(6, C_SOD, 32'h61);
        send(6, C_EOD, 32'h62);
        up_ready = 1'b1;
        expect_beat("dsod_b0", 6, C_SOD, 32'h60);
        expect_beat("dsod_b1", 6, C_SOD, 32'h61);
        expect_beat("dsod_b2", 6, C_EOD, 32'h62);
        check("dsod_err", 64'(lane_err), 64'hC0);

        // ---------------- reset mid-packet ----------------
        up_ready = 1'b0;
        send(9, C_SOD, 32'h90);
        send(9, C_MOD, 32'h91);
        tick();
        check("mid_locked_valid", 64'(up_valid), 64'd1);
        reset_poweron = 1'b1;
        tick();
        check("mid_rst_valid", 64'(up_valid), 64'd0);
        check("mid_rst_busy",  64'(busy), 64'd0);
        check("mid_rst_err",   64'(lane_err), 64'd0);
        check("mid_rst_ready", 64'(lane_ready), 64'hFFFF_FFFF);
        reset_poweron = 1'b0;
        up_ready      = 1'b1;
        tick();
        send(9, C_SE, 32'h99);
        expect_beat("post_rst", 9, C_SE, 32'h99);
        check("post_rst_err", 64'(lane_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
